// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller.
// Keeps the X and O boards, accepts and validates moves, and looks for a
// completed line in the cycle after each accepted move. The win/draw flags
// stay set until the game is cleared.
module ttt_game_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       play,
  input  logic [3:0] pos,
  output logic       ready,
  output logic       turn,
  output logic [8:0] x_board,
  output logic [8:0] o_board,
  output logic [3:0] move_cnt,
  output logic       illegal,
  output logic       x_wins,
  output logic       o_wins,
  output logic       draw,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] x_board_q, x_board_d;
  logic [8:0] o_board_q, o_board_d;
  logic       turn_q, turn_d;
  logic [3:0] move_cnt_q, move_cnt_d;
  logic       illegal_q, illegal_d;
  logic       x_wins_q, x_wins_d;
  logic       o_wins_q, o_wins_d;
  logic       draw_q, draw_d;

  logic [8:0] pos_mask;
  logic       pos_ok;
  logic       cell_free;
  logic [8:0] mover_board;
  logic       mover_won;

  // True when any of the eight winning lines is fully occupied in b.
  function automatic logic has_line(input logic [8:0] b);
    return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  // Cell decode and evaluation of the board belonging to the player who just moved.
  always_comb begin
    pos_ok      = (pos <= 4'd8);
    pos_mask    = 9'd1 << pos;
    cell_free   = ((x_board_q | o_board_q) & pos_mask) == 9'd0;
    mover_board = turn_q ? o_board_q : x_board_q;
    mover_won   = has_line(mover_board);
  end

  // Next-state logic: a clear wins over everything else; play only matters in PLAY.
  always_comb begin
    state_d    = state_q;
    x_board_d  = x_board_q;
    o_board_d  = o_board_q;
    turn_d     = turn_q;
    move_cnt_d = move_cnt_q;
    illegal_d  = 1'b0;
    x_wins_d   = x_wins_q;
    o_wins_d   = o_wins_q;
    draw_d     = draw_q;
    if (new_game) begin
      state_d    = S_PLAY;
      x_board_d  = 9'd0;
      o_board_d  = 9'd0;
      turn_d     = 1'b0;
      move_cnt_d = 4'd0;
      x_wins_d   = 1'b0;
      o_wins_d   = 1'b0;
      draw_d     = 1'b0;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (play) begin
            if (pos_ok && cell_free) begin
              if (turn_q) o_board_d = o_board_q | pos_mask;
              else        x_board_d = x_board_q | pos_mask;
              move_cnt_d = move_cnt_q + 4'd1;
              state_d    = S_CHECK;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        S_CHECK: begin
          // A win on the last free cell is reported as a win, not a draw.
          if (mover_won) begin
            if (turn_q) o_wins_d = 1'b1;
            else        x_wins_d = 1'b1;
            state_d = S_DONE;
          end else if (move_cnt_q == 4'd9) begin
            draw_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            turn_d  = ~turn_q;
            state_d = S_PLAY;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_PLAY;
        end
      endcase
    end
  end

  // State register with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_PLAY;
      x_board_q  <= 9'd0;
      o_board_q  <= 9'd0;
      turn_q     <= 1'b0;
      move_cnt_q <= 4'd0;
      illegal_q  <= 1'b0;
      x_wins_q   <= 1'b0;
      o_wins_q   <= 1'b0;
      draw_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_board_q  <= x_board_d;
      o_board_q  <= o_board_d;
      turn_q     <= turn_d;
      move_cnt_q <= move_cnt_d;
      illegal_q  <= illegal_d;
      x_wins_q   <= x_wins_d;
      o_wins_q   <= o_wins_d;
      draw_q     <= draw_d;
    end
  end

  // Output mapping straight from registers.
  always_comb begin
    ready     = (state_q == S_PLAY);
    game_over = (state_q == S_DONE);
    turn      = turn_q;
    x_board   = x_board_q;
    o_board   = o_board_q;
    move_cnt  = move_cnt_q;
    illegal   = illegal_q;
    x_wins    = x_wins_q;
    o_wins    = o_wins_q;
    draw      = draw_q;
  end

endmodule
